pulse_event_counter: RTL



---
 rtl/pulse_event_counter_pkg.sv | 14 +
 rtl/pulse_event_counter_sync_chain.sv | 26 ++
 rtl/pulse_event_counter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/pulse_event_counter_pkg.sv
// Shared defaults and helpers for the pulse event counter and other slow-domain CDC consumers.
package pulse_event_counter_pkg;

  localparam int unsigned PEC_SYNC_STAGES_DEFAULT = 32'd2;
  localparam int unsigned PEC_MIN_IDLE_DEFAULT    = 32'd2;

  // Gap counter must hold values 1..min_idle.
  function automatic int unsigned gap_width(input int unsigned min_idle);
    int unsigned w;
    w = $clog2(min_idle + 32'd1);
    return (w < 32'd1) ? 32'd1 : w;
  endfunction

endpackage

// File: rtl/pulse_event_counter_sync_chain.sv
// sync_chain: generic multi-flop synchroniser for asynchronous inputs, reset to a chosen idle value.
module sync_chain #(
  parameter int unsigned          WIDTH  = 32'd1,
  parameter int unsigned          STAGES = 32'd2,
  parameter logic [WIDTH-1:0]     INIT   = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(STAGES); i++) r_stage[i] <= INIT;
    end else begin
      r_stage[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign q = r_stage[STAGES-1];

endmodule

// File: rtl/pulse_event_counter.sv
// Turns a stretched asynchronous pulse level into single events with re-trigger rejection and a saturating count.
// Optional PULSE_EVENT_TIMESTAMP_EN adds a free-running cycle counter and a ts_o event timestamp.
module pulse_event_counter
  import pulse_event_counter_pkg::*;
#(
  parameter bit          PULSE_VALUE = 1'b1,
  parameter int unsigned SYNC_STAGES = PEC_SYNC_STAGES_DEFAULT,
  parameter int unsigned MIN_IDLE    = PEC_MIN_IDLE_DEFAULT,
  parameter int unsigned COUNT_WIDTH = 32'd16,
  parameter int unsigned THRESHOLD   = 32'd1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   dat_i,
  input  logic                   cnt_clr,
  output logic                   evt_o,
  output logic [COUNT_WIDTH-1:0] cnt_o,
  output logic                   irq_o,
  output logic                   ovf_o
`ifdef PULSE_EVENT_TIMESTAMP_EN
  ,
  output logic [COUNT_WIDTH-1:0] ts_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  localparam int unsigned            GW  = gap_width(MIN_IDLE);
  localparam logic [GW-1:0]          GAP_LAST = GW'(MIN_IDLE);
  localparam logic [COUNT_WIDTH-1:0] THR = COUNT_WIDTH'(THRESHOLD);

  logic                   w_s;
  state_t                 r_state, w_state_nxt;
  logic [GW-1:0]          r_gap, w_gap_nxt;
  logic                   w_evt;
  logic                   r_evt;
  logic [COUNT_WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic                   r_irq;
  logic                   r_ovf, w_ovf_nxt;

  sync_chain #(
    .WIDTH (32'd1),
    .STAGES(SYNC_STAGES),
    .INIT  (~PULSE_VALUE)
  ) u_sync (
    .clk(clk),
    .rst(rst),
    .d  (dat_i),
    .q  (w_s)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_gap_nxt   = r_gap;
    w_evt       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_s == PULSE_VALUE) begin
          w_state_nxt = ST_ACTIVE;
          w_evt       = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (w_s != PULSE_VALUE) begin
          w_state_nxt = ST_GAP;
          w_gap_nxt   = GW'(1);
        end
      end
      ST_GAP: begin
        // A pulse inside the gap re-arms ACTIVE silently: it is a re-trigger, not an event.
        if (w_s == PULSE_VALUE) begin
          w_state_nxt = ST_ACTIVE;
        end else if (r_gap == GAP_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_nxt = r_gap + GW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_gap_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_cnt_nxt = r_cnt;
    w_ovf_nxt = r_ovf;
    // Clear wins over overflow but still counts a coincident event.
    if (cnt_clr) begin
      w_cnt_nxt = w_evt ? COUNT_WIDTH'(1) : '0;
      w_ovf_nxt = 1'b0;
    end else if (w_evt) begin
      if (&r_cnt) w_ovf_nxt = 1'b1;
      else        w_cnt_nxt = r_cnt + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_gap   <= '0;
      r_evt   <= 1'b0;
      r_cnt   <= '0;
      r_irq   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_gap   <= w_gap_nxt;
      r_evt   <= w_evt;
      r_cnt   <= w_cnt_nxt;
      r_irq   <= (w_cnt_nxt >= THR);
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign evt_o = r_evt;
  assign cnt_o = r_cnt;
  assign irq_o = r_irq;
  assign ovf_o = r_ovf;

`ifdef PULSE_EVENT_TIMESTAMP_EN
  logic [COUNT_WIDTH-1:0] r_cyc;
  logic [COUNT_WIDTH-1:0] r_ts;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc <= '0;
      r_ts  <= '0;
    end else begin
      r_cyc <= r_cyc + COUNT_WIDTH'(1);
      if (w_evt) r_ts <= r_cyc;
    end
  end

  assign ts_o = r_ts;
`endif

endmodule
